// File: rtl/ospi_controller.sv
// Behavioural octal-SPI memory controller: single-word load/store over valid/ready with in-order tagged load responses.
// Optional build macro OSPI_CTRL_RD0_DROP_EN suppresses the response pulse for loads tagged rd == 0.
package ospi_controller_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } pend_t;
endpackage

module ospi_controller
    import ospi_controller_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 256,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        ospi_cs_n,
    output logic        ospi_sck,
    inout  wire  [7:0]  ospi_io,
    output logic        ospi_oe
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(RD_LATENCY + 1);

    logic [31:0]      mem [MEM_WORDS];
    pend_t            slot_q [FIFO_DEPTH];
    logic [AGE_W-1:0] age_q [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             ready_q;

    logic             accept_c;
    logic             push_c;
    logic             pop_c;
    logic             rd_ok_c;
    logic [CNT_W-1:0] count_nxt_c;
    logic [IDX_W-1:0] idx_c;
    logic             unused_addr;

    // External pins are parked idle in this revision
    assign ospi_cs_n = 1'b1;
    assign ospi_sck  = 1'b0;
    assign ospi_oe   = 1'b0;
    assign ospi_io   = 'z;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready comes from the registered occupancy only; reset forces it low
    assign req_ready   = ready_q & rst_n;
    assign accept_c    = req_valid & req_ready;
    assign push_c      = accept_c & req_is_load;
    assign pop_c       = (count_q != '0) && (age_q[head_q] >= AGE_W'(RD_LATENCY));
    assign idx_c       = req_addr[2 +: IDX_W];
    assign unused_addr = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

`ifdef OSPI_CTRL_RD0_DROP_EN
    assign rd_ok_c = (slot_q[head_q].rd != 5'd0);
`else
    assign rd_ok_c = 1'b1;
`endif

    always_comb begin
        count_nxt_c = count_q;
        if (push_c && !pop_c) begin
            count_nxt_c = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_nxt_c = count_q - CNT_W'(1);
        end
    end

    // Memory model: not reset, so contents survive rst_n
    always_ff @(posedge clk) begin
        if (accept_c && !req_is_load) begin
            mem[idx_c] <= req_wdata;
        end
    end

    // Load data is captured at acceptance, so a later store cannot alter it
    always_ff @(posedge clk) begin
        if (push_c) begin
            slot_q[tail_q] <= '{rd: req_rd, data: mem[idx_c]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            resp_valid <= 1'b0;
            resp_rd    <= '0;
            resp_data  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                age_q[i] <= '0;
            end
        end else begin
            count_q <= count_nxt_c;
            ready_q <= (count_nxt_c < CNT_W'(FIFO_DEPTH));
            if (push_c) begin
                tail_q <= next_ptr(tail_q);
            end
            if (pop_c) begin
                head_q <= next_ptr(head_q);
            end
            // Age counts edges since acceptance, saturating at the latency
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                if (push_c && (tail_q == PTR_W'(i))) begin
                    age_q[i] <= AGE_W'(1);
                end else if (age_q[i] < AGE_W'(RD_LATENCY)) begin
                    age_q[i] <= age_q[i] + AGE_W'(1);
                end
            end
            resp_valid <= pop_c & rd_ok_c;
            resp_rd    <= pop_c ? slot_q[head_q].rd   : 5'd0;
            resp_data  <= pop_c ? slot_q[head_q].data : 32'd0;
        end
    end

endmodule

// File: tb/tb_ospi_controller.sv
// Self-checking bench for ospi_controller: table-driven load/store vectors with a response scoreboard,
// plus hand-written back-pressure, read-snapshot and mid-flight reset sequences.
module tb_ospi_controller;

    localparam int unsigned L    = 2;
    localparam int unsigned BP_L = 8;

    typedef struct {
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // Main instance
    logic        rst_n, req_valid, req_is_load, req_ready, resp_valid, cs_n, sck, oe;
    logic [31:0] req_addr, req_wdata, resp_data;
    logic [4:0]  req_rd, resp_rd;
    wire  [7:0]  io;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (io[i]);
    end

    ospi_controller #(.MEM_WORDS(256), .RD_LATENCY(L), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_load(req_is_load),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
        .ospi_cs_n(cs_n), .ospi_sck(sck), .ospi_io(io), .ospi_oe(oe)
    );

    // Long-latency instance so the FIFO can actually fill
    logic        bp_rst_n, bp_valid, bp_is_load, bp_ready, bp_resp_valid, bp_cs_n, bp_sck, bp_oe;
    logic [31:0] bp_addr, bp_wdata, bp_resp_data;
    logic [4:0]  bp_rd, bp_resp_rd;
    wire  [7:0]  bp_io;

    ospi_controller #(.MEM_WORDS(256), .RD_LATENCY(BP_L), .FIFO_DEPTH(4)) u_bp (
        .clk(clk), .rst_n(bp_rst_n), .req_valid(bp_valid), .req_is_load(bp_is_load),
        .req_addr(bp_addr), .req_wdata(bp_wdata), .req_rd(bp_rd), .req_ready(bp_ready),
        .resp_valid(bp_resp_valid), .resp_rd(bp_resp_rd), .resp_data(bp_resp_data),
        .ospi_cs_n(bp_cs_n), .ospi_sck(bp_sck), .ospi_io(bp_io), .ospi_oe(bp_oe)
    );

    exp_t q_main[$];
    exp_t q_bp[$];
    exp_t em, eb;
    vec_t vecs[8];
    int   acc[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboards: each response must match the oldest expectation on its due cycle
    always @(negedge clk) begin
        if (resp_valid) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_resp", resp_valid, 1'b0);
            end else begin
                em = q_main.pop_front();
                chk("main_resp_rd", 32'(resp_rd), 32'(em.rd));
                chk("main_resp_data", resp_data, em.data);
                chk("main_resp_cycle", cyc, em.due);
            end
        end
    end

    always @(negedge clk) begin
        if (bp_resp_valid) begin
            if (q_bp.size() == 0) begin
                chk("bp_unexpected_resp", bp_resp_valid, 1'b0);
            end else begin
                eb = q_bp.pop_front();
                chk("bp_resp_rd", 32'(bp_resp_rd), 32'(eb.rd));
                chk("bp_resp_data", bp_resp_data, eb.data);
                chk("bp_resp_cycle", cyc, eb.due);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with req_valid still high
    task automatic issue(input logic ld, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] ex);
        int w;
        w = 0;
        req_valid = 1'b1; req_is_load = ld; req_addr = a; req_wdata = wd; req_rd = rd;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("main_accept_timeout", req_ready, 1'b1);
            return;
        end
        if (ld) q_main.push_back('{rd: rd, data: ex, due: cyc + 1 + int'(L)});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{1'b0, 32'h0000_0000, 32'hA5A5_0001, 5'd0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h5A5A_0002, 5'd0, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 5'd0, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0000, 32'h0,         5'd1, 32'hA5A5_0001};
        vecs[4] = '{1'b1, 32'h0000_0004, 32'h0,         5'd2, 32'h5A5A_0002};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'h0,         5'd3, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'h0000_0400, 32'h1122_3344, 5'd0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0,         5'd4, 32'h1122_3344};

        rst_n = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        bp_rst_n = 1'b0; bp_valid = 1'b0; bp_is_load = 1'b0; bp_addr = '0; bp_wdata = '0; bp_rd = '0;

        repeat (4) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_oe", oe, 1'b0);
        chk("rst_io_released", 32'(io), 32'h0000_00FF);
        chk("rst_ready_low", req_ready, 1'b0);
        rst_n = 1'b1; bp_rst_n = 1'b1;
        #1;
        chk("rel_ready_high", req_ready, 1'b1);
        chk("rel_bp_ready_high", bp_ready, 1'b1);
        @(negedge clk);

        // Stores then back-to-back loads, plus address wrap
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].ld, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].exp_data);
        end
        issue(1'b1, 32'h0000_0003, 32'h0, 5'd5, 32'h1122_3344);
        req_valid = 1'b0;
        repeat (L + 2) @(negedge clk);

        // Read snapshot: a store right after a load must not alter that load's data
        issue(1'b1, 32'h0000_0000, 32'h0, 5'd6, 32'h1122_3344);
        issue(1'b0, 32'h0000_0000, 32'hCAFE_F00D, 5'd0, 32'h0);
        issue(1'b1, 32'h0000_0000, 32'h0, 5'd7, 32'hCAFE_F00D);
        req_valid = 1'b0;
        repeat (L + 2) @(negedge clk);

        // Back-pressure on the long-latency instance
        for (int k = 0; k < 5; k++) begin
            bp_valid = 1'b1; bp_is_load = 1'b0; bp_addr = 32'(k * 4); bp_wdata = 32'h1000_0000 + 32'(k);
            w = 0;
            while (!bp_ready && w < 40) begin @(negedge clk); w++; end
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            bp_valid = 1'b1; bp_is_load = 1'b1; bp_addr = 32'(k * 4); bp_rd = 5'(16 + k);
            w = 0;
            while (!bp_ready && w < 40) begin @(negedge clk); w++; end
            if (!bp_ready) begin
                chk("bp_accept_timeout", bp_ready, 1'b1);
                acc[k] = 0;
            end else begin
                acc[k] = cyc + 1;
                q_bp.push_back('{rd: 5'(16 + k), data: 32'h1000_0000 + 32'(k), due: cyc + 1 + int'(BP_L)});
                @(posedge clk);
                @(negedge clk);
            end
            if (k == 3) chk("bp_full_ready_low", bp_ready, 1'b0);
        end
        bp_valid = 1'b0;
        chk("bp_fifth_accept_cycle", 32'(acc[4]), 32'(acc[0] + int'(BP_L) + 1));

        // Reset while two loads are in flight: both responses must vanish
        issue(1'b1, 32'h0000_0004, 32'h0, 5'd8, 32'h5A5A_0002);
        issue(1'b1, 32'h0000_0008, 32'h0, 5'd9, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        rst_n = 1'b0;
        q_main.delete();
        #1;
        chk("midrst_ready_low", req_ready, 1'b0);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_resp", resp_valid, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 32'h0000_0004, 32'h0, 5'd10, 32'h5A5A_0002);
        issue(1'b1, 32'h0000_0008, 32'h0, 5'd11, 32'hDEAD_BEEF);
        issue(1'b1, 32'h0000_0000, 32'h0, 5'd12, 32'hCAFE_F00D);
        req_valid = 1'b0;

        w = 0;
        while ((q_main.size() != 0 || q_bp.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_main_queue", 32'(q_main.size()), 32'd0);
        chk("drain_bp_queue", 32'(q_bp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
